// File: rtl/rtc_pkg.sv
// Shared definitions for the HH:MM:SS wall-clock controller.
//  - rtc_state_e : controller mode codes (also exported on state_dbg)
//  - SEG_TABLE   : 7-segment patterns for BCD 0..9, segments a..g on bits 6..0
//  - BCD_*       : two-digit BCD limits used by the carry chain
//  - bcd_step    : two-digit BCD +1 without any wrap handling
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_MIN = 2'd1,
    ST_SET_HR  = 2'd2
  } rtc_state_e;

  // Index 0 is the rightmost entry, so the list reads 9 down to 0.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
    7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_11 = 8'h11;

  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/rtc_hhmmss_ctrl_if.sv
// Board-side bundle of the wall-clock controller.
//  adv_btn, inc_btn          : raw button levels (asynchronous to clock)
//  hr_*, mn_*, sc_*          : registered BCD time digits
//  pm                        : PM flag (12h build only)
//  state_dbg                 : current controller mode code
//  seg_hr_*, seg_mn_*, colon : display drive, a..g on bits 6..0, active-high
// There is no valid/ready handshake on this bundle: buttons are plain levels
// sampled every clock and every output is a continuously valid level.
// master = controller side, slave = board/button side.
interface rtc_hhmmss_ctrl_if;
  logic       adv_btn;
  logic       inc_btn;
  logic [3:0] hr_t;
  logic [3:0] hr_u;
  logic [3:0] mn_t;
  logic [3:0] mn_u;
  logic [3:0] sc_t;
  logic [3:0] sc_u;
  logic       pm;
  logic [1:0] state_dbg;
  logic [6:0] seg_hr_t;
  logic [6:0] seg_hr_u;
  logic [6:0] seg_mn_t;
  logic [6:0] seg_mn_u;
  logic       colon;

  modport master (
    input  adv_btn, inc_btn,
    output hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, pm, state_dbg,
    output seg_hr_t, seg_hr_u, seg_mn_t, seg_mn_u, colon
  );

  modport slave (
    output adv_btn, inc_btn,
    input  hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, pm, state_dbg,
    input  seg_hr_t, seg_hr_u, seg_mn_t, seg_mn_u, colon
  );
endinterface

// File: rtl/seg7_bcd.sv
// BCD digit to 7-segment decoder.
//  bcd : 4-bit digit in
//  seg : segments a..g on bits 6..0, active-high; codes A..F show blank
module seg7_bcd
  import rtc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/rtc_hhmmss_ctrl.sv
// Wall-clock controller: BCD HH:MM:SS from a divided system clock, button
// driven minute/hour setting, 4-digit 7-segment drive with blinking colon.
//  clock : system clock, all state on the rising edge
//  reset : synchronous, active-low
//  bus   : rtc_hhmmss_ctrl_if.master (buttons in, time/pm/state/segments out)
// Parameters:
//  TICK_DIV : system clocks per second (>=2, even)
//  MODE_12H : 0 = hours 00..23, 1 = hours 12,01..11 with pm flag
//  BLINK_EN : 1 = field under adjustment blanks in 2nd half of each second
module rtc_hhmmss_ctrl
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MODE_12H = 0,
  parameter int BLINK_EN = 1
) (
  input logic               clock,
  input logic               reset,
  rtc_hhmmss_ctrl_if.master bus
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_HALF = PW'(TICK_DIV / 2);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
  localparam logic           IS_12H   = (MODE_12H != 0);
  localparam logic           BLINK    = (BLINK_EN != 0);

  // Button synchronisers: meta -> sync_q is the 2-FF synchroniser, sync_qq
  // is the edge-detect history. A rising input is acted on at the third edge.
  logic adv_meta, adv_sync_q, adv_sync_qq;
  logic inc_meta, inc_sync_q, inc_sync_qq;
  logic adv_pulse, inc_pulse;

  rtc_state_e    state;
  logic [PW-1:0] pre;
  logic [7:0]    hr_q, mn_q, sc_q;
  logic          pm_q;

  assign adv_pulse = adv_sync_q & ~adv_sync_qq;
  assign inc_pulse = inc_sync_q & ~inc_sync_qq;

  // Carry chain stages: each stage computes its +1 value and its carry-out.
  logic          pre_wrap;
  logic [PW-1:0] pre_next;
  logic [7:0]    sc_inc, mn_inc, hr_inc;
  logic          sc_carry, mn_carry, hr_pm_flip;

  always_comb begin
    pre_wrap = (pre == PRE_LAST);
    pre_next = pre_wrap ? '0 : pre + PRE_ONE;

    sc_carry = (sc_q == BCD_59);
    sc_inc   = sc_carry ? 8'h00 : bcd_step(sc_q);

    mn_carry = (mn_q == BCD_59);
    mn_inc   = mn_carry ? 8'h00 : bcd_step(mn_q);

    // In 12h mode the pm flag flips on 11 -> 12, not on 12 -> 01.
    hr_inc     = bcd_step(hr_q);
    hr_pm_flip = 1'b0;
    if (IS_12H) begin
      if (hr_q == BCD_12) begin
        hr_inc = 8'h01;
      end else if (hr_q == BCD_11) begin
        hr_inc     = BCD_12;
        hr_pm_flip = 1'b1;
      end
    end else if (hr_q == BCD_23) begin
      hr_inc = 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      adv_meta    <= 1'b0;
      adv_sync_q  <= 1'b0;
      adv_sync_qq <= 1'b0;
      inc_meta    <= 1'b0;
      inc_sync_q  <= 1'b0;
      inc_sync_qq <= 1'b0;
      state       <= ST_RUN;
      pre         <= '0;
      hr_q        <= IS_12H ? BCD_12 : 8'h00;
      mn_q        <= 8'h00;
      sc_q        <= 8'h00;
      pm_q        <= 1'b0;
    end else begin
      adv_meta    <= bus.adv_btn;
      adv_sync_q  <= adv_meta;
      adv_sync_qq <= adv_sync_q;
      inc_meta    <= bus.inc_btn;
      inc_sync_q  <= inc_meta;
      inc_sync_qq <= inc_sync_q;

      // The prescaler keeps running in the set modes as the blink timebase.
      pre <= pre_next;

      // adv is tested first in every mode, so a coincident inc is dropped.
      case (state)
        ST_SET_MIN: begin
          if (adv_pulse) begin
            state <= ST_SET_HR;
          end else if (inc_pulse) begin
            mn_q <= mn_inc;
          end
        end

        ST_SET_HR: begin
          if (adv_pulse) begin
            state <= ST_RUN;
            pre   <= '0;  // first second after setting is a full one
          end else if (inc_pulse) begin
            hr_q <= hr_inc;
            if (hr_pm_flip) pm_q <= ~pm_q;
          end
        end

        // RUN, and the unused code 3 which behaves exactly like RUN.
        default: begin
          if (adv_pulse) begin
            state <= ST_SET_MIN;
            sc_q  <= 8'h00;
          end else if (pre_wrap) begin
            sc_q <= sc_inc;
            if (sc_carry) begin
              mn_q <= mn_inc;
              if (mn_carry) begin
                hr_q <= hr_inc;
                if (hr_pm_flip) pm_q <= ~pm_q;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.hr_t      = hr_q[7:4];
  assign bus.hr_u      = hr_q[3:0];
  assign bus.mn_t      = mn_q[7:4];
  assign bus.mn_u      = mn_q[3:0];
  assign bus.sc_t      = sc_q[7:4];
  assign bus.sc_u      = sc_q[3:0];
  assign bus.pm        = pm_q;
  assign bus.state_dbg = state;

  // Display drive, combinational from registered state.
  logic       half, in_set_min, in_set_hr, blank_mn, blank_hr;
  logic [6:0] raw_hr_t, raw_hr_u, raw_mn_t, raw_mn_u;

  assign half       = (pre >= PRE_HALF);
  assign in_set_min = (state == ST_SET_MIN);
  assign in_set_hr  = (state == ST_SET_HR);
  assign blank_mn   = BLINK & half & in_set_min;
  assign blank_hr   = BLINK & half & in_set_hr;

  seg7_bcd u_seg_hr_t (.bcd(hr_q[7:4]), .seg(raw_hr_t));
  seg7_bcd u_seg_hr_u (.bcd(hr_q[3:0]), .seg(raw_hr_u));
  seg7_bcd u_seg_mn_t (.bcd(mn_q[7:4]), .seg(raw_mn_t));
  seg7_bcd u_seg_mn_u (.bcd(mn_q[3:0]), .seg(raw_mn_u));

  assign bus.seg_hr_t = blank_hr ? SEG_BLANK : raw_hr_t;
  assign bus.seg_hr_u = blank_hr ? SEG_BLANK : raw_hr_u;
  assign bus.seg_mn_t = blank_mn ? SEG_BLANK : raw_mn_t;
  assign bus.seg_mn_u = blank_mn ? SEG_BLANK : raw_mn_u;
  assign bus.colon    = (in_set_min | in_set_hr) ? 1'b1 : ~half;

endmodule

// File: tb/tb_rtc_hhmmss_ctrl.sv
// Directed bench for rtc_hhmmss_ctrl with TICK_DIV=4: one 24h and one 12h
// instance share clock and reset; each has its own bundle and buttons.
// Inputs change and outputs are sampled on the falling edge.
module tb_rtc_hhmmss_ctrl;

  localparam int TD = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  rtc_hhmmss_ctrl_if if24 ();
  rtc_hhmmss_ctrl_if if12 ();

  rtc_hhmmss_ctrl #(.TICK_DIV(TD), .MODE_12H(0), .BLINK_EN(1)) dut24 (
    .clock (clock),
    .reset (reset),
    .bus   (if24)
  );

  rtc_hhmmss_ctrl #(.TICK_DIV(TD), .MODE_12H(1), .BLINK_EN(1)) dut12 (
    .clock (clock),
    .reset (reset),
    .bus   (if12)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int since_rst = 0;  // rising edges since reset release = prescaler phase source

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] t24();
    return {if24.hr_t, if24.hr_u, if24.mn_t, if24.mn_u, if24.sc_t, if24.sc_u};
  endfunction

  function automatic logic [23:0] t12();
    return {if12.hr_t, if12.hr_u, if12.mn_t, if12.mn_u, if12.sc_t, if12.sc_u};
  endfunction

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      since_rst++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    since_rst = 0;
  endtask

  // Press for `hold` clocks, release, then let the synchroniser drain.
  // The mode/field change lands on the 3rd rising edge; 7 edges in total.
  task automatic press(input bit on12, input bit adv, input bit inc, input int hold = 4);
    if (on12) begin
      if12.adv_btn = adv;
      if12.inc_btn = inc;
    end else begin
      if24.adv_btn = adv;
      if24.inc_btn = inc;
    end
    cycles(hold);
    if (on12) begin
      if12.adv_btn = 1'b0;
      if12.inc_btn = 1'b0;
    end else begin
      if24.adv_btn = 1'b0;
      if24.inc_btn = 1'b0;
    end
    cycles(3);
  endtask

  task automatic incs(input bit on12, input int n);
    for (int i = 0; i < n; i++) press(on12, 1'b0, 1'b1);
  endtask

  // Four consecutive samples of the 24h display; the field under adjustment
  // must be blank exactly when the prescaler phase is 2 or 3.
  task automatic blink4(input string tag, input bit hr_field, input logic [27:0] segs);
    for (int i = 0; i < 4; i++) begin
      logic [27:0] exp;
      exp = segs;
      if ((since_rst % TD) >= TD / 2) begin
        if (hr_field) exp[27:14] = '0;
        else          exp[13:0]  = '0;
      end
      check(tag, {if24.seg_hr_t, if24.seg_hr_u, if24.seg_mn_t, if24.seg_mn_u}, exp);
      cycles(1);
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    if24.adv_btn = 1'b0;
    if24.inc_btn = 1'b0;
    if12.adv_btn = 1'b0;
    if12.inc_btn = 1'b0;

    // Reset values
    reset = 1'b0;
    cycles(2);
    check("rst24_time",  t24(), 24'h000000);
    check("rst24_state", if24.state_dbg, 2'd0);
    check("rst24_colon", if24.colon, 1'b1);
    check("rst24_seg",   {if24.seg_hr_t, if24.seg_mn_u}, {7'h7E, 7'h7E});
    check("rst12_time",  t12(), 24'h120000);
    check("rst12_pm",    if12.pm, 1'b0);
    reset = 1'b1;
    since_rst = 0;

    // 1. free run
    cycles(240);
    check("run_240",     t24(), 24'h000100);
    check("run_seg_mn",  {if24.seg_mn_t, if24.seg_mn_u}, {7'h7E, 7'h30});
    check("run_colon1",  if24.colon, 1'b1);
    cycles(4);
    check("run_244",     t24(), 24'h000101);
    check("run_12h",     t12(), 24'h120101);
    cycles(2);
    check("run_colon0",  if24.colon, 1'b0);
    check("run_246",     t24(), 24'h000101);

    // 3. set minutes
    do_reset();
    cycles(12);
    check("pre_set",     t24(), 24'h000003);
    press(1'b0, 1'b1, 1'b0);
    check("setmin_st",   if24.state_dbg, 2'd1);
    check("setmin_sc0",  t24(), 24'h000000);
    check("setmin_colon", if24.colon, 1'b1);
    blink4("blink_mn", 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E});
    incs(1'b0, 3);
    check("setmin_03",   t24(), 24'h000300);
    incs(1'b0, 56);
    check("setmin_59",   t24(), 24'h005900);
    incs(1'b0, 1);
    check("setmin_wrap", t24(), 24'h000000);
    incs(1'b0, 59);
    check("setmin_59b",  t24(), 24'h005900);

    // 5. set hours, held button counts once
    press(1'b0, 1'b1, 1'b0);
    check("sethr_st",    if24.state_dbg, 2'd2);
    incs(1'b0, 22);
    check("sethr_22",    t24(), 24'h225900);
    blink4("blink_hr", 1'b1, {7'h6D, 7'h6D, 7'h5B, 7'h7B});
    check("sethr_bcd",   t24(), 24'h225900);
    press(1'b0, 1'b0, 1'b1, 100);
    check("sethr_hold",  t24(), 24'h235900);

    // 2. back to RUN, cross midnight
    press(1'b0, 1'b1, 1'b0);
    check("run_st",      if24.state_dbg, 2'd0);
    check("run_first",   t24(), 24'h235901);
    cycles(232);
    check("pre_mid",     t24(), 24'h235959);
    cycles(4);
    check("midnight",    t24(), 24'h000000);
    check("pm24_tied",   if24.pm, 1'b0);

    // 4. simultaneous adv + inc
    press(1'b0, 1'b1, 1'b1);
    check("both_run_st", if24.state_dbg, 2'd1);
    check("both_run_t",  t24(), 24'h000000);
    press(1'b0, 1'b1, 1'b1);
    check("both_min_st", if24.state_dbg, 2'd2);
    check("both_min_t",  t24(), 24'h000000);
    incs(1'b0, 1);
    check("hr_01",       t24(), 24'h010000);

    // 6. reset in SET_HR mid-count
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check("mid_rst_st",  if24.state_dbg, 2'd0);
    check("mid_rst_t",   t24(), 24'h000000);
    check("mid_rst_col", if24.colon, 1'b1);
    check("mid_rst_12",  {t12(), 7'd0, if12.pm}, {24'h120000, 8'h00});
    reset = 1'b1;
    since_rst = 0;
    cycles(3);
    check("rst_pre3",    {t24(), 7'd0, if24.colon}, {24'h000000, 8'h00});
    cycles(1);
    check("rst_pre4",    {t24(), 7'd0, if24.colon}, {24'h000001, 8'h01});

    // 12h mode
    press(1'b1, 1'b1, 1'b0);
    check("h12_setmin",  t12(), 24'h120000);
    incs(1'b1, 59);
    press(1'b1, 1'b1, 1'b0);
    check("h12_sethr",   if12.state_dbg, 2'd2);
    incs(1'b1, 1);
    check("h12_12to01",  {t12(), 7'd0, if12.pm}, {24'h015900, 8'h00});
    incs(1'b1, 10);
    check("h12_11",      {t12(), 7'd0, if12.pm}, {24'h115900, 8'h00});
    press(1'b1, 1'b1, 1'b0);
    check("h12_run",     {t12(), 7'd0, if12.pm}, {24'h115901, 8'h00});
    cycles(232);
    check("h12_1159",    {t12(), 7'd0, if12.pm}, {24'h115959, 8'h00});
    cycles(4);
    check("h12_noon",    {t12(), 7'd0, if12.pm}, {24'h120000, 8'h01});
    cycles(3599 * 4);
    check("h12_1259",    {t12(), 7'd0, if12.pm}, {24'h125959, 8'h01});
    cycles(4);
    check("h12_0100",    {t12(), 7'd0, if12.pm}, {24'h010000, 8'h01});
    press(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    incs(1'b1, 10);
    check("h12_set11",   {t12(), 7'd0, if12.pm}, {24'h110000, 8'h01});
    incs(1'b1, 1);
    check("h12_set12",   {t12(), 7'd0, if12.pm}, {24'h120000, 8'h00});

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
